instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 23 ++
 rtl/instr_fetch_unit_fifo.sv | 63 ++++++
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit and its prefetch buffer.
package instr_fetch_unit_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;

  localparam int              DEPTH_DEFAULT  = 2;
  localparam logic [PC_W-1:0] END_PC_DEFAULT = 8'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  // One prefetch buffer entry: the instruction word tagged with its word address.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch buffer: shift-down FIFO whose slot 0 is always the head, so the
// head entry comes straight out of flops. Flush wins over push and pop.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem      [DEPTH];
  fetch_entry_t  mem_next [DEPTH];
  logic [CW-1:0] count_next;
  logic          do_push;
  logic          do_pop;
  logic [IW-1:0] wr_idx;

  // A pop frees the last occupied slot in the same cycle, so a full buffer
  // still accepts a push when it is also being popped.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign wr_idx  = IW'(count - CW'(do_pop));
  assign head    = mem[0];

  // Next storage contents: shift down on pop, then write the new entry at the first free slot.
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise untouched paths infer latches.
    mem_next   = mem;
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem_next[i] = mem[i + 1];
      end
      if (do_push) mem_next[wr_idx] = push_entry;
      count_next = count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: storage is reset here because slot 0 drives outputs that must read zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      mem   <= mem_next;
      count <= count_next;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks PC from 0 up to END_PC against a synchronous
// ROM, buffers returned words in a small prefetch FIFO and hands them to the
// core with a valid/ready handshake. A redirect flushes everything and
// restarts at the new address.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              DEPTH  = DEPTH_DEFAULT,
  parameter logic [PC_W-1:0] END_PC = END_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               done
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            active;
  logic            accept_start;
  logic            take_redirect;
  logic            at_end;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     credits_used;

  assign active        = (state == RUN) || (state == DRAIN);
  assign accept_start  = start && ((state == IDLE) || (state == DONE));
  assign take_redirect = redirect_valid && active;
  assign at_end        = (pc == END_PC);

  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !take_redirect;
  assign push        = inflight && !take_redirect;
  assign push_entry  = '{pc: inflight_pc, instr: imem_rdata};

  // Credits cover buffered plus in-flight words; the head leaving this cycle
  // frees its slot in time for the word issued now, which keeps one
  // instruction per cycle with only two entries. instr_ready reaches only the
  // D side of the PC flop, so imem_addr stays a pure register output.
  assign credits_used = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = (state == RUN) && !take_redirect && !at_end &&
                 (credits_used < (CW+1)'(DEPTH));

  assign imem_addr  = pc;
  assign instr_data = head.instr;
  assign instr_pc   = head.pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (take_redirect),
    .head       (head),
    .count      (count)
  );

  // Next-state decode; a redirect always lands in RUN.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN: begin
        if (take_redirect) state_next = RUN;
        else if (at_end)   state_next = DRAIN;
      end
      DRAIN: begin
        if (take_redirect)                      state_next = RUN;
        else if ((count == '0) && !inflight)    state_next = DONE;
      end
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // State register with a registered done flag that tracks the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state_next == DONE);
    end
  end

  // PC and the single in-flight read tracker; the tag is the address issued this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight    <= issue;
      inflight_pc <= pc;
      if (accept_start)       pc <= '0;
      else if (take_redirect) pc <= redirect_pc;
      else if (issue)         pc <= pc + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a main instance (DEPTH 2, END_PC 4)
// and a wrap instance (DEPTH 3, END_PC 0), each fed by a one-cycle ROM model.
module tb_instr_fetch_unit;

  localparam int DEPTH_A = 2;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;

  logic        start;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [7:0]  instr_pc;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        done;

  logic        start_w;
  logic [7:0]  imem_addr_w;
  logic [31:0] imem_rdata_w;
  logic        instr_valid_w;
  logic        ready_w;
  logic [31:0] instr_data_w;
  logic [7:0]  instr_pc_w;
  logic        redirect_valid_w;
  logic [7:0]  redirect_pc_w;
  logic        done_w;

  int   passed;
  int   total;
  exp_t sb[$];

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    case (a)
      8'd0:    rom_word = 32'h0050_0093;
      8'd1:    rom_word = 32'h0030_0113;
      8'd2:    rom_word = 32'h0020_81B3;
      8'd3:    rom_word = 32'h4020_8233;
      default: rom_word = {24'hC0FFEE, a};
    endcase
  endfunction

  instr_fetch_unit #(
    .DEPTH  (DEPTH_A),
    .END_PC (8'd4)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .done           (done)
  );

  instr_fetch_unit #(
    .DEPTH  (3),
    .END_PC (8'd0)
  ) u_dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .start          (start_w),
    .imem_addr      (imem_addr_w),
    .imem_rdata     (imem_rdata_w),
    .instr_valid    (instr_valid_w),
    .instr_ready    (ready_w),
    .instr_data     (instr_data_w),
    .instr_pc       (instr_pc_w),
    .redirect_valid (redirect_valid_w),
    .redirect_pc    (redirect_pc_w),
    .done           (done_w)
  );

  always #5 clk = ~clk;

  // Synchronous ROMs: data valid one cycle after the address is presented.
  always_ff @(posedge clk) begin
    imem_rdata   <= rom_word(imem_addr);
    imem_rdata_w <= rom_word(imem_addr_w);
  end

  task automatic push_stream();
    sb.delete();
    for (int i = 0; i < 4; i++) sb.push_back('{pc: 8'(i), data: rom_word(8'(i))});
  endtask

  // Waits (bounded) for one transfer on the main instance; returns at posedge+1.
  task automatic wait_transfer(input int budget, output logic [7:0] pc,
                               output logic [31:0] data, output bit seen);
    seen = 1'b0;
    pc   = '0;
    data = '0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        seen = 1'b1;
        pc   = instr_pc;
        data = instr_data;
      end
      @(posedge clk); #1;
    end
  endtask

  // Waits (bounded) for done on the main instance; samples instr_valid alongside.
  task automatic wait_done(input int budget, output bit seen, output logic valid_at_done);
    seen = 1'b0;
    valid_at_done = 1'b1;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        valid_at_done = instr_valid;
      end
    end
    @(posedge clk); #1;
  endtask

  // Pops four scoreboard entries against four handshakes.
  task automatic collect_four(input string tag);
    logic [7:0]  pc;
    logic [31:0] data;
    bit          seen;
    exp_t        e;
    for (int i = 0; i < 4; i++) begin
      wait_transfer(30, pc, data, seen);
      e = sb.pop_front();
      total++;
      if (!seen) $display("FAIL %s_timeout[%0d]: no transfer, expected pc %0d", tag, i, e.pc);
      else passed++;
      total++;
      if ({pc, data} !== {e.pc, e.data})
        $display("FAIL %s_xfer[%0d]: got pc %0d data %h, expected pc %0d data %h", tag, i, pc, data, e.pc, e.data);
      else passed++;
    end
  endtask

  task automatic finish_check(input string tag);
    bit   seen;
    logic v;
    wait_done(20, seen, v);
    total++;
    if (!seen) $display("FAIL %s_done: done never asserted", tag);
    else passed++;
    total++;
    if (v !== 1'b0) $display("FAIL %s_done_valid: instr_valid %b while done, expected 0", tag, v);
    else passed++;
    total++;
    if (sb.size() != 0) $display("FAIL %s_leftover: %0d expected words never transferred", tag, sb.size());
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    total++;
    if ({imem_addr, instr_valid, instr_data, instr_pc, done} !== '0)
      $display("FAIL reset_outputs: got addr %h valid %b data %h pc %h done %b, expected all 0",
               imem_addr, instr_valid, instr_data, instr_pc, done);
    else passed++;
    total++;
    if ({imem_addr_w, instr_valid_w, done_w} !== '0)
      $display("FAIL reset_wrap: got addr %h valid %b done %b, expected 0", imem_addr_w, instr_valid_w, done_w);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if ({imem_addr, instr_valid, done} !== '0)
      $display("FAIL idle_hold: got addr %h valid %b done %b, expected 0", imem_addr, instr_valid, done);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_redirect_idle();
    redirect_valid = 1'b1;
    redirect_pc    = 8'd7;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({imem_addr, instr_valid} !== 9'd0)
      $display("FAIL redirect_idle: got addr %0d valid %b, expected 0 0", imem_addr, instr_valid);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    exp_t e;
    instr_ready = 1'b1;
    start = 1'b1;
    push_stream();
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b0) $display("FAIL stream_latency[%0d]: valid %b, expected 0", c, instr_valid);
      else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({instr_valid, instr_pc, instr_data} !== {1'b1, e.pc, e.data})
        $display("FAIL stream_xfer[%0d]: got valid %b pc %0d data %h, expected 1 pc %0d data %h",
                 i, instr_valid, instr_pc, instr_data, e.pc, e.data);
      else passed++;
    end
    finish_check("stream");
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    start = 1'b1;
    push_stream();
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b0) $display("FAIL restart_done: done %b after start from DONE, expected 0", done);
    else passed++;
    repeat (10) @(posedge clk);
    @(negedge clk);
    total++;
    if (imem_addr !== 8'(DEPTH_A))
      $display("FAIL stall_issued: imem_addr %0d, expected %0d", imem_addr, DEPTH_A);
    else passed++;
    total++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 8'd0, 32'h0050_0093})
      $display("FAIL stall_head: got valid %b pc %0d data %h, expected 1 pc 0 data 00500093",
               instr_valid, instr_pc, instr_data);
    else passed++;
    @(posedge clk); #1;
    instr_ready = 1'b1;
    collect_four("stall");
    finish_check("stall");
  endtask

  task automatic test_toggle();
    exp_t e;
    int   got;
    bit   fin;
    got = 0;
    fin = 1'b0;
    instr_ready = 1'b0;
    start = 1'b1;
    push_stream();
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
      instr_ready = ((cyc % 2) == 1);
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        got++;
        total++;
        if (sb.size() == 0) begin
          $display("FAIL toggle_extra: unexpected pc %0d", instr_pc);
        end else begin
          e = sb.pop_front();
          if ({instr_pc, instr_data} !== {e.pc, e.data})
            $display("FAIL toggle_xfer: got pc %0d data %h, expected pc %0d data %h",
                     instr_pc, instr_data, e.pc, e.data);
          else passed++;
        end
      end
      if (done) fin = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (!fin || got != 4) $display("FAIL toggle_count: got %0d transfers done %b, expected 4 and 1", got, fin);
    else passed++;
  endtask

  task automatic test_redirect();
    exp_t e;
    int   got;
    bit   fin;
    got = 0;
    fin = 1'b0;
    instr_ready = 1'b0;
    start = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if ({instr_valid, instr_pc} !== {1'b1, 8'd0})
      $display("FAIL redir_pre: got valid %b pc %0d, expected 1 pc 0", instr_valid, instr_pc);
    else passed++;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 8'd2;
    for (int i = 2; i < 4; i++) sb.push_back('{pc: 8'(i), data: rom_word(8'(i))});
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({instr_valid, imem_addr} !== {1'b0, 8'd2})
      $display("FAIL redir_flush: got valid %b addr %0d, expected 0 addr 2", instr_valid, imem_addr);
    else passed++;
    @(posedge clk); #1;
    instr_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        got++;
        total++;
        if (sb.size() == 0) begin
          $display("FAIL redir_extra: unexpected pc %0d", instr_pc);
        end else begin
          e = sb.pop_front();
          if ({instr_pc, instr_data} !== {e.pc, e.data})
            $display("FAIL redir_xfer: got pc %0d data %h, expected pc %0d data %h",
                     instr_pc, instr_data, e.pc, e.data);
          else passed++;
        end
      end
      if (done) fin = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (!fin || got != 2) $display("FAIL redir_count: got %0d transfers done %b, expected 2 and 1", got, fin);
    else passed++;
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b1) $display("FAIL rstmid_pre: valid %b, expected 1", instr_valid);
    else passed++;
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({imem_addr, instr_valid, instr_data, instr_pc, done} !== '0)
      $display("FAIL rstmid_outputs: got addr %h valid %b data %h pc %h done %b, expected all 0",
               imem_addr, instr_valid, instr_data, instr_pc, done);
    else passed++;
    @(posedge clk); #3;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b0) $display("FAIL rstmid_nopush: valid %b after reset, expected 0", instr_valid);
    else passed++;
    @(posedge clk); #1;
    instr_ready = 1'b1;
    start = 1'b1;
    push_stream();
    @(posedge clk); #1;
    start = 1'b0;
    collect_four("rstmid");
    finish_check("rstmid");
  endtask

  task automatic test_wrap();
    exp_t e;
    int   got;
    bit   fin;
    got = 0;
    fin = 1'b0;
    sb.delete();
    sb.push_back('{pc: 8'd255, data: rom_word(8'd255)});
    ready_w = 1'b1;
    start_w = 1'b1;
    @(posedge clk); #1;
    start_w = 1'b0;
    redirect_valid_w = 1'b1;
    redirect_pc_w    = 8'd255;
    @(posedge clk); #1;
    redirect_valid_w = 1'b0;
    @(negedge clk);
    total++;
    if ({imem_addr_w, done_w} !== {8'd255, 1'b0})
      $display("FAIL wrap_issue: got addr %0d done %b, expected 255 0", imem_addr_w, done_w);
    else passed++;
    @(negedge clk);
    total++;
    if ({imem_addr_w, done_w} !== {8'd0, 1'b0})
      $display("FAIL wrap_pc: got addr %0d done %b, expected 0 0", imem_addr_w, done_w);
    else passed++;
    for (int cyc = 0; cyc < 30 && !fin; cyc++) begin
      @(negedge clk);
      if (instr_valid_w && ready_w) begin
        got++;
        total++;
        if (sb.size() == 0) begin
          $display("FAIL wrap_extra: unexpected pc %0d", instr_pc_w);
        end else begin
          e = sb.pop_front();
          if ({instr_pc_w, instr_data_w, done_w} !== {e.pc, e.data, 1'b0})
            $display("FAIL wrap_xfer: got pc %0d data %h done %b, expected pc %0d data %h done 0",
                     instr_pc_w, instr_data_w, done_w, e.pc, e.data);
          else passed++;
        end
      end
      if (done_w) fin = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (!fin || got != 1 || imem_addr_w !== 8'd0)
      $display("FAIL wrap_done: got %0d transfers done %b addr %0d, expected 1, 1, 0", got, fin, imem_addr_w);
    else passed++;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    start = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    start_w = 1'b0;
    ready_w = 1'b0;
    redirect_valid_w = 1'b0;
    redirect_pc_w = '0;
    passed = 0;
    total = 0;

    test_reset();
    test_redirect_idle();
    test_stream();
    test_stall();
    test_toggle();
    test_redirect();
    test_reset_mid();
    test_wrap();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
